fifo_stream_reader: RTL

Read-side master for the synchronous FIFO. It drains words through the FIFO's rd_en/empty/data_out port and presents them downstream as a valid/ready stream. A 3-entry skid buffer absorbs the FIFO's one-cycle read latency, so the block sustains one word per clock with no combinational path from m_ready to fifo_rd_en. Sits between the FIFO and any consumer that needs backpressure instead of a raw read strobe.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/skid_buf3.sv | 59 +++++
 rtl/fifo_stream_reader.sv | 62 ++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its stream-side readers.
package fifo_pkg;

    localparam int unsigned FIFO_WIDTH = 16;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned SKID_DEPTH = 3;

    typedef logic [FIFO_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2,
        OCC_FULL  = 2'd3
    } occ_t;

    typedef logic [1:0] idx_t;

    // Circular index over SKID_DEPTH entries: 0 -> 1 -> 2 -> 0.
    function automatic idx_t idx_inc(input idx_t i);
        return (i == idx_t'(SKID_DEPTH - 1)) ? '0 : i + 2'd1;
    endfunction

endpackage

// File: rtl/skid_buf3.sv
// Three-entry circular skid buffer; occupancy is tracked as an explicit state.
module skid_buf3
    import fifo_pkg::*;
#(
    parameter int unsigned W = FIFO_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         valid,
    output logic [1:0]   level
);

    logic [W-1:0] mem [SKID_DEPTH];
    idx_t         rd_idx;
    idx_t         wr_idx;
    occ_t         occ;
    occ_t         occ_next;
    logic         do_pop;

    assign valid    = (occ != OCC_EMPTY);
    assign do_pop   = pop & valid;
    assign pop_data = mem[rd_idx];
    assign level    = occ;

    always_comb begin
        occ_next = occ;
        unique case ({push, do_pop})
            2'b10:   occ_next = occ_t'(occ + 2'd1);
            2'b01:   occ_next = occ_t'(occ - 2'd1);
            default: occ_next = occ;
        endcase
    end

    // Storage is cleared on reset so the downstream data bus reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ    <= OCC_EMPTY;
            rd_idx <= '0;
            wr_idx <= '0;
            for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            occ <= occ_next;
            if (push) begin
                mem[wr_idx] <= push_data;
                wr_idx      <= idx_inc(wr_idx);
            end
            if (do_pop) begin
                rd_idx <= idx_inc(rd_idx);
            end
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains the synchronous FIFO into a valid/ready stream at one word per clock.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned BEAT_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic [BEAT_CNT_W-1:0] beat_count,
    output logic                  err_underflow
);

    logic       inflight;
    logic       pop;
    logic [1:0] occ_lvl;
    logic [2:0] pending;

    // Reads are issued only when a slot is guaranteed for the returning word,
    // so backpressure never has to reach the FIFO combinationally.
    assign pending    = {1'b0, occ_lvl} + {2'b00, inflight};
    assign fifo_rd_en = rst_n & en & ~fifo_empty & (pending < 3'(SKID_DEPTH));
    assign pop        = m_valid & m_ready;

    skid_buf3 #(
        .W (FIFO_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (fifo_data_out),
        .pop       (pop),
        .pop_data  (m_data),
        .valid     (m_valid),
        .level     (occ_lvl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight      <= 1'b0;
            beat_count    <= '0;
            err_underflow <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            if (pop) begin
                beat_count <= beat_count + BEAT_CNT_W'(1);
            end
            if (fifo_underflow) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule
